vc_output_arbiter: RTL and testbench

VC_OUTPUT_ARBITER -- requirements
Module: vc_output_arbiter

---
 rtl/vc_output_arbiter_if.sv | 35 +++
 rtl/vc_output_arbiter.sv | 132 +++++++++++++
 tb/tb_vc_output_arbiter.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/vc_output_arbiter_if.sv
// Handshake bundle between two virtual-channel front flits, the output
// switch and the arbiter; master drives VC status, slave is the arbiter.
interface vc_output_arbiter_if;
  logic        vc0_valid;
  logic        vc0_head;
  logic        vc0_tail;
  logic        vc1_valid;
  logic        vc1_head;
  logic        vc1_tail;
  logic        out_ready;
  logic        sel;
  logic        out_valid;
  logic        vc0_pop;
  logic        vc1_pop;
  logic        busy;
  logic [15:0] pkt_cnt;
  logic        framing_err;
  logic        timeout_err;

  modport master (
    output vc0_valid, vc0_head, vc0_tail,
    output vc1_valid, vc1_head, vc1_tail,
    output out_ready,
    input  sel, out_valid, vc0_pop, vc1_pop, busy, pkt_cnt,
    input  framing_err, timeout_err
  );

  modport slave (
    input  vc0_valid, vc0_head, vc0_tail,
    input  vc1_valid, vc1_head, vc1_tail,
    input  out_ready,
    output sel, out_valid, vc0_pop, vc1_pop, busy, pkt_cnt,
    output framing_err, timeout_err
  );
endinterface

// File: rtl/vc_output_arbiter.sv
// Two-VC wormhole output arbiter: a head flit locks the output until its tail.
// Optional lock watchdog enabled by defining VC_ARB_TIMEOUT_EN.
module vc_output_arbiter #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic              clk,
  input  logic              reset,
  vc_output_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, LOCK0, LOCK1} state_e;

  state_e      state_q, state_d;
  logic        rr_ptr_q, rr_ptr_d;
  logic [15:0] pkt_cnt_q, pkt_cnt_d;

  logic sel_c, out_valid_c, pop0_c, pop1_c, ferr_c, tout_c;
  logic elig0, elig1, win, lk, xfer;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

`ifdef VC_ARB_TIMEOUT_EN
  localparam int STALL_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [STALL_W-1:0] stall_q, stall_d;
`endif

  assign elig0 = bus.vc0_valid & bus.vc0_head;
  assign elig1 = bus.vc1_valid & bus.vc1_head;

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    pkt_cnt_d   = pkt_cnt_q;
    sel_c       = rr_ptr_q;
    out_valid_c = 1'b0;
    pop0_c      = 1'b0;
    pop1_c      = 1'b0;
    ferr_c      = 1'b0;
    tout_c      = 1'b0;
    win         = rr_ptr_q;
    lk          = 1'b0;
    xfer        = 1'b0;
`ifdef VC_ARB_TIMEOUT_EN
    stall_d     = '0;
`endif
    case (state_q)
      IDLE: begin
        if (elig0 && elig1) win = rr_ptr_q;
        else if (elig0)     win = 1'b0;
        else if (elig1)     win = 1'b1;
        sel_c = win;
        if (elig0 || elig1) begin
          out_valid_c = 1'b1;
          if (bus.out_ready) begin
            pop0_c = ~win;
            pop1_c = win;
            if (win ? bus.vc1_tail : bus.vc0_tail) begin
              rr_ptr_d  = ~win;
              pkt_cnt_d = pkt_cnt_q + 16'd1;
            end else begin
              state_d = win ? LOCK1 : LOCK0;
            end
          end
        end else if (bus.out_ready && (bus.vc0_valid || bus.vc1_valid)) begin
          // Body flit with no packet open: drop it, oldest-numbered VC first.
          ferr_c = 1'b1;
          pop0_c = bus.vc0_valid;
          pop1_c = ~bus.vc0_valid;
        end
      end
      LOCK0, LOCK1: begin
        lk          = (state_q == LOCK1);
        sel_c       = lk;
        out_valid_c = lk ? bus.vc1_valid : bus.vc0_valid;
        xfer        = out_valid_c & bus.out_ready;
        if (xfer) begin
          pop0_c = ~lk;
          pop1_c = lk;
          if (lk ? bus.vc1_tail : bus.vc0_tail) begin
            state_d   = IDLE;
            rr_ptr_d  = ~lk;
            pkt_cnt_d = pkt_cnt_q + 16'd1;
          end
        end
`ifdef VC_ARB_TIMEOUT_EN
        else if (stall_q == STALL_W'(TIMEOUT_CYCLES - 1)) begin
          // Abandon the stuck packet without counting it as completed.
          state_d  = IDLE;
          rr_ptr_d = ~lk;
          tout_c   = 1'b1;
        end else begin
          stall_d = stall_q + 1'b1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      rr_ptr_q  <= 1'b0;
      pkt_cnt_q <= 16'd0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      pkt_cnt_q <= pkt_cnt_d;
    end
  end

`ifdef VC_ARB_TIMEOUT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) stall_q <= '0;
    else        stall_q <= stall_d;
  end
  assign bus.timeout_err = tout_c;
`else
  assign bus.timeout_err = 1'b0;
`endif

  assign bus.sel         = sel_c;
  assign bus.out_valid   = out_valid_c;
  assign bus.vc0_pop     = pop0_c;
  assign bus.vc1_pop     = pop1_c;
  assign bus.framing_err = ferr_c;
  assign bus.busy        = (state_q != IDLE);
  assign bus.pkt_cnt     = pkt_cnt_q;

endmodule

// File: tb/tb_vc_output_arbiter.sv
// Directed bench for vc_output_arbiter; timeout expectations follow VC_ARB_TIMEOUT_EN.
module tb_vc_output_arbiter;
  logic clk = 1'b0;
  logic reset;
  int   tests = 0;
  int   fails = 0;
  logic [15:0] exp_cnt;
  logic exp_to;

  vc_output_arbiter_if bus();

  vc_output_arbiter #(.TIMEOUT_CYCLES(4)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic s, input logic ov,
                         input logic p0, input logic p1, input logic b, input logic fe);
    chk1({tag, ".sel"},         bus.sel,         s);
    chk1({tag, ".out_valid"},   bus.out_valid,   ov);
    chk1({tag, ".vc0_pop"},     bus.vc0_pop,     p0);
    chk1({tag, ".vc1_pop"},     bus.vc1_pop,     p1);
    chk1({tag, ".busy"},        bus.busy,        b);
    chk1({tag, ".framing_err"}, bus.framing_err, fe);
  endtask

  task automatic drive(input logic v0, input logic h0, input logic t0,
                       input logic v1, input logic h1, input logic t1, input logic rdy);
    bus.vc0_valid = v0; bus.vc0_head = h0; bus.vc0_tail = t0;
    bus.vc1_valid = v1; bus.vc1_head = h1; bus.vc1_tail = t1;
    bus.out_ready = rdy;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    drive(0,0,0, 0,0,0, 0);
    exp_cnt = 16'd0;
    #12;
    chk_out("rst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk16("rst.pkt_cnt", bus.pkt_cnt, 16'd0);
    chk1("rst.timeout_err", bus.timeout_err, 1'b0);
    reset = 1'b1;
    step();

    // Both VCs with 3-flit packets: VC0 first, then VC1.
    drive(1,1,0, 1,1,0, 1); #1; chk_out("p3.c0", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0); step();
    drive(1,0,0, 1,1,0, 1); #1; chk_out("p3.c1", 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0); step();
    drive(1,0,1, 1,1,0, 1); #1; chk_out("p3.c2", 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0); step();
    chk16("p3.cnt1", bus.pkt_cnt, 16'd1);
    drive(1,1,0, 1,1,0, 1); #1; chk_out("p3.c3", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0); step();
    drive(1,1,0, 1,0,0, 1); #1; chk_out("p3.c4", 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0); step();
    drive(1,1,0, 1,0,1, 1); #1; chk_out("p3.c5", 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0); step();
    chk16("p3.cnt2", bus.pkt_cnt, 16'd2);
    exp_cnt = 16'd2;

    // VC0 locked; VC1 head must wait, including through a bubble and a stall.
    drive(1,1,0, 1,1,0, 1); #1; chk_out("lk.head",   1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0); step();
    drive(0,0,0, 1,1,0, 1); #1; chk_out("lk.bubble", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0); step();
    drive(1,0,1, 1,1,0, 0); #1; chk_out("lk.stall",  1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0); step();
    chk16("lk.cnt_hold", bus.pkt_cnt, exp_cnt);
    drive(1,0,1, 1,1,0, 1); #1; chk_out("lk.tail",   1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0); step();
    exp_cnt++;
    chk16("lk.cnt", bus.pkt_cnt, exp_cnt);

    // Single-flit packets on both VCs alternate starting from VC1 (rr_ptr=1).
    for (int i = 0; i < 4; i++) begin
      drive(1,1,1, 1,1,1, 1); #1;
      chk_out("sf", (i % 2 == 0), 1'b1, (i % 2 != 0), (i % 2 == 0), 1'b0, 1'b0);
      step();
      exp_cnt++;
      chk16("sf.cnt", bus.pkt_cnt, exp_cnt);
    end

    // Headless flits in IDLE are discarded, VC0 before VC1; none while stalled.
    drive(0,0,0, 1,0,0, 1); #1; chk_out("fr.vc1",  1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1); step();
    drive(1,0,0, 1,0,0, 1); #1; chk_out("fr.both", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1); step();
    drive(1,0,0, 0,0,0, 0); #1; chk_out("fr.nrdy", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); step();
    chk16("fr.cnt", bus.pkt_cnt, exp_cnt);

    // Head flag inside a locked packet is plain data.
    drive(1,1,0, 0,0,0, 1); #1; chk_out("hd.first", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0); step();
    drive(1,1,0, 0,0,0, 1); #1; chk_out("hd.mid",   1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0); step();
    drive(1,0,1, 0,0,0, 1); #1; chk_out("hd.tail",  1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0); step();
    exp_cnt++;
    chk16("hd.cnt", bus.pkt_cnt, exp_cnt);

    // VC1 locks then starves for four cycles.
    drive(0,0,0, 1,1,0, 1); #1; chk_out("to.head", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0); step();
    for (int i = 0; i < 4; i++) begin
      drive(0,0,0, 0,0,0, 1); #1;
      chk_out("to.stall", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      exp_to = 1'b0;
`ifdef VC_ARB_TIMEOUT_EN
      exp_to = (i == 3);
`endif
      chk1("to.timeout_err", bus.timeout_err, exp_to);
      step();
    end
`ifdef VC_ARB_TIMEOUT_EN
    chk1("to.busy_after", bus.busy, 1'b0);
`else
    chk1("to.busy_after", bus.busy, 1'b1);
    drive(0,0,0, 1,0,1, 1); #1; chk_out("to.tail", 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0); step();
    exp_cnt++;
`endif
    chk16("to.cnt", bus.pkt_cnt, exp_cnt);
    drive(1,1,1, 1,1,1, 1); #1; chk_out("to.next", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0); step();
    exp_cnt++;

    // Drive the counter to 0xFFFF, then one more tail wraps it.
    drive(1,1,1, 0,0,0, 1);
    while (exp_cnt != 16'hFFFF) begin
      step();
      exp_cnt++;
    end
    chk16("wrap.ffff", bus.pkt_cnt, 16'hFFFF);
    step();
    chk16("wrap.zero", bus.pkt_cnt, 16'h0000);

    // Reset in the middle of a VC1 packet drops the lock immediately.
    drive(0,0,0, 1,1,0, 1); #1; chk_out("mr.head", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0); step();
    drive(0,0,0, 1,0,0, 0); #1;
    chk1("mr.busy_pre", bus.busy, 1'b1);
    chk1("mr.sel_pre",  bus.sel,  1'b1);
    #1; reset = 1'b0; #1;
    chk_out("mr.in_rst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk16("mr.cnt", bus.pkt_cnt, 16'd0);
    reset = 1'b1;
    step();
    drive(0,0,0, 1,0,0, 1); #1; chk_out("mr.body", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1); step();
    chk1("mr.busy_post", bus.busy, 1'b0);
    drive(0,0,0, 1,1,1, 1); #1; chk_out("mr.fresh", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0); step();
    chk16("mr.cnt1", bus.pkt_cnt, 16'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
